// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters.
// Lookups are combinational; resolved-branch updates and flushes commit on the rising edge.
module branch_target_predictor #(
    parameter int XLEN        = 32,
    parameter int BTB_ENTRIES = 64,
    parameter int CTR_BITS    = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            lookup_valid,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic            upd_is_jump,
    input  logic [XLEN-1:0] upd_target,
    input  logic            flush
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
    localparam logic [CTR_BITS-1:0] WEAK_T  = CTR_BITS'(1 << (CTR_BITS - 1));

    logic                valid_q  [BTB_ENTRIES];
    logic [TAG_W-1:0]    tag_q    [BTB_ENTRIES];
    logic [XLEN-1:0]     target_q [BTB_ENTRIES];
    logic [CTR_BITS-1:0] ctr_q    [BTB_ENTRIES];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             up_hit, up_en, alloc, write_target;
    logic [CTR_BITS-1:0] ctr_cur, ctr_next;

    // The low two PC bits never select or tag an entry.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign lk_idx = lookup_pc[IDX_W+1:2];
    assign lk_tag = lookup_pc[XLEN-1:IDX_W+2];
    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[XLEN-1:IDX_W+2];

    // Lookup reads pre-update state, so a same-cycle update is not forwarded.
    assign pred_hit    = lookup_valid & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
    assign pred_taken  = pred_hit & ctr_q[lk_idx][CTR_BITS-1];
    assign pred_target = pred_taken ? target_q[lk_idx] : lookup_pc + XLEN'(4);

    assign up_en   = upd_valid & ~flush & ~rst;
    assign up_hit  = valid_q[up_idx] & (tag_q[up_idx] == up_tag);
    assign ctr_cur = ctr_q[up_idx];

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        ctr_next     = ctr_cur;
        alloc        = 1'b0;
        write_target = 1'b0;
        if (up_hit) begin
            if (upd_is_jump) begin
                ctr_next     = CTR_MAX;
                write_target = 1'b1;
            end else if (upd_taken) begin
                if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + CTR_BITS'(1);
                write_target = 1'b1;
            end else if (ctr_cur != '0) begin
                ctr_next = ctr_cur - CTR_BITS'(1);
            end
        end else if (upd_taken) begin
            alloc        = 1'b1;
            write_target = 1'b1;
            ctr_next     = upd_is_jump ? CTR_MAX : WEAK_T;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                ctr_q[i]   <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < BTB_ENTRIES; i++) valid_q[i] <= 1'b0;
        end else if (upd_valid) begin
            if (alloc) valid_q[up_idx] <= 1'b1;
            ctr_q[up_idx] <= ctr_next;
        end
    end

    // NOTE: tag/target storage has no reset; an entry's contents only matter once its valid bit is set.
    always_ff @(posedge clk) begin
        if (up_en && write_target) target_q[up_idx] <= upd_target;
        if (up_en && alloc)        tag_q[up_idx]    <= up_tag;
    end

endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Parametrised direct-mapped branch target buffer with per-entry N-bit saturating direction counters. Sits beside the IF stage: the fetch PC is looked up combinationally each cycle to steer the next PC. Branch/jump outcomes resolved in EX write back through a single update port. Generalises the fixed 64-entry / 2-bit prediction scheme to configurable depth and counter width, with unconditional-jump training and a bulk flush.

## Interface
Parameters:
- XLEN, 32, address/data width.
- BTB_ENTRIES, 64, number of entries; power of two, ≥ 2.
- CTR_BITS, 2, direction counter width; ≥ 1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- lookup_valid  in  1  fetch PC valid this cycle.
- lookup_pc  in  XLEN  fetch PC.
- pred_hit  out  1  valid entry with matching tag.
- pred_taken  out  1  predict taken.
- pred_target  out  XLEN  predicted next PC.
- upd_valid  in  1  resolved branch/jump update this cycle.
- upd_pc  in  XLEN  PC of the resolved instruction.
- upd_taken  in  1  actual outcome; 1 for all jumps.
- upd_is_jump  in  1  JAL/JALR (unconditional).
- upd_target  in  XLEN  actual target address.
- flush  in  1  invalidate all entries.

## Operation
- IDX_W = log2(BTB_ENTRIES).
- index = pc[IDX_W+1:2].
- tag = pc[XLEN-1:IDX_W+2].
- pc[1:0] ignored everywhere.
- Entry fields: valid, tag, target (XLEN), ctr (CTR_BITS).
- CTR_MAX = 2^CTR_BITS − 1.
- WEAK_T = 2^(CTR_BITS−1); the taken threshold is ctr MSB = 1.

Lookup (combinational):
- hit = lookup_valid & valid[idx] & tag match.
- pred_hit = hit.
- pred_taken = hit & ctr[idx] MSB.
- pred_target = target[idx] when pred_taken, else lookup_pc + 4 (modulo 2^XLEN, so 0xFFFFFFFC wraps to 0x0).

Update (registered, when upd_valid & ~flush):
- **Hit, upd_is_jump:**
  - ctr ← CTR_MAX.
  - target ← upd_target.
- **Hit, conditional, taken:**
  - ctr ← min(ctr + 1, CTR_MAX).
  - target ← upd_target.
- **Hit, conditional, not taken:**
  - ctr ← max(ctr − 1, 0).
  - target unchanged.
- **Miss, taken:** allocate or replace the entry at index.
  - valid ← 1, tag ← upd tag, target ← upd_target.
  - ctr ← CTR_MAX if upd_is_jump, else WEAK_T.
- **Miss, not taken:** no state change (no allocation).

Flush and reset:
- flush: all valid ← 0 next edge. A same-cycle update is discarded (flush wins).
- rst: all valid ← 0 and all ctr ← 0. Tag and target contents are don't-care.

## Timing
- Lookup latency: 0 cycles, pure combinational from lookup_pc and current state.
- Update and flush take effect at the next rising edge and are visible to lookups from the following cycle.
- Same-cycle lookup and update to the same index: the lookup sees pre-update state.
- Single update port: at most one update per cycle; no back-pressure; no handshake.
- Output values during and after reset (entries invalid):
  - pred_hit = 0.
  - pred_taken = 0.
  - pred_target = lookup_pc + 4.
- lookup_valid = 0 forces pred_hit = pred_taken = 0 and pred_target = lookup_pc + 4.
- Reset asserted mid-operation: state clears on that edge; any concurrent update is dropped.

## Test plan
1. **Reset/cold miss.**
   - Stimulus: rst 1 cycle, then lookup 0x100.
   - Required: pred_hit=0, pred_taken=0, pred_target=0x104.
2. **Allocation and training** (CTR_BITS=2).
   - Stimulus: update pc=0x100, taken, target=0x200, not jump.
   - Required: next-cycle lookup 0x100 gives hit=1, taken=1 (ctr=2), target=0x200.
   - Stimulus: then two not-taken updates.
   - Required: ctr=0, taken=0, target=0x104.
   - Stimulus: then three taken updates.
   - Required: ctr saturates at 3, and one subsequent not-taken update still predicts taken.
3. **Alias/replacement** (BTB_ENTRIES=64).
   - Stimulus: train 0x100 taken to 0x200, then update 0x200 (same index, different tag) taken to 0x300.
   - Required: lookup 0x100 misses; lookup 0x200 hits with target 0x300.
   - Stimulus: not-taken update at 0x400 (miss).
   - Required: no change to entry state.
4. **Jump training.**
   - Stimulus: update pc=0x80, jump, target=0x40.
   - Required: ctr=3, and one not-taken conditional update still predicts taken.
5. **Flush.**
   - Stimulus: flush asserted together with a taken update to 0x300.
   - Required: next cycle, all lookups (0x100, 0x300) miss.
6. **Same-cycle read/write.**
   - Stimulus: lookup 0x500 and a taken update to 0x500 in the same cycle.
   - Required: that cycle gives hit=0; the next cycle gives hit=1.
   - Stimulus: repeat with parameters BTB_ENTRIES=4, CTR_BITS=3.
   - Required: correct index/tag split; a new allocation gives ctr=4.
